// File: rtl/cnn_frame_io.sv
// Host-side frame controller for the CNN core: loads one frame into the engine image RAM,
// starts the engine, streams the feature map out of the result RAM and recycles the engine.
module cnn_frame_io #(
    parameter int IMG_W        = 8,
    parameter int IMG_H        = 8,
    parameter int WAIT_TIMEOUT = 4096,
    parameter int ENG_RST_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        img_ram [IMG_W*IMG_H],
    output logic               eng_start,
    output logic               eng_rst,
    input  logic               eng_done,
    input  logic signed [31:0] res_ram [(IMG_W-2)*(IMG_H-2)],
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    input  logic               abort,
    output logic               busy,
    output logic               err
);
    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int N_OUT  = (IMG_W - 2) * (IMG_H - 2);
    localparam int PIX_W  = $clog2(N_PIX + 1);
    localparam int PIX_AW = $clog2(N_PIX);
    localparam int OUT_W  = $clog2(N_OUT + 1);
    localparam int OUT_AW = $clog2(N_OUT);
    localparam int WAIT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam int RST_W  = $clog2(ENG_RST_CYC + 1);

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(N_PIX - 1);
    localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(N_OUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_TIMEOUT > 0) ? WAIT_W'(WAIT_TIMEOUT - 1) : '0;
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(ENG_RST_CYC);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_KICK    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    state_t            state_r;
    logic [PIX_W-1:0]  pix_cnt_r;
    logic [OUT_W-1:0]  out_idx_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [RST_W-1:0]  rst_cnt_r;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              fill_wr_s;
    logic [OUT_W-1:0]  nxt_idx_s;

    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;
    assign fill_wr_s  = (state_r == ST_FILL) && in_xfer_s && !abort;
    assign nxt_idx_s  = out_idx_r + OUT_W'(1);

    // Image RAM write port: one pixel per accepted FILL transfer, never on an aborted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PIX; i++) begin
                img_ram[i] <= 32'd0;
            end
        end else if (fill_wr_s) begin
            img_ram[pix_cnt_r[PIX_AW-1:0]] <= in_data;
        end
    end

    // Frame sequencing FSM; all handshake and engine-control outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_RECOVER;
            pix_cnt_r  <= '0;
            out_idx_r  <= '0;
            wait_cnt_r <= '0;
            rst_cnt_r  <= RST_LOAD;
            in_ready   <= 1'b0;
            eng_start  <= 1'b0;
            eng_rst    <= 1'b1;
            out_data   <= 32'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // The word that wakes us is left on the bus and taken in FILL.
                    if (in_valid) begin
                        state_r  <= ST_FILL;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (abort) begin
                        state_r   <= ST_RECOVER;
                        rst_cnt_r <= RST_LOAD;
                        eng_rst   <= 1'b1;
                        in_ready  <= 1'b0;
                    end else if (in_xfer_s) begin
                        pix_cnt_r <= pix_cnt_r + PIX_W'(1);
                        if (pix_cnt_r == PIX_LAST) begin
                            state_r   <= ST_KICK;
                            in_ready  <= 1'b0;
                            eng_start <= 1'b1;
                        end
                    end
                end
                ST_KICK: begin
                    if (abort) begin
                        state_r   <= ST_RECOVER;
                        rst_cnt_r <= RST_LOAD;
                        eng_rst   <= 1'b1;
                    end else begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= '0;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_r   <= ST_RECOVER;
                        rst_cnt_r <= RST_LOAD;
                        eng_rst   <= 1'b1;
                    end else if (eng_done) begin
                        state_r   <= ST_DRAIN;
                        out_idx_r <= '0;
                        out_data  <= res_ram[0];
                        out_valid <= 1'b1;
                        out_last  <= (N_OUT == 1);
                    end else if (WAIT_TIMEOUT != 0) begin
                        if (wait_cnt_r == WAIT_LAST) begin
                            err       <= 1'b1;
                            state_r   <= ST_RECOVER;
                            rst_cnt_r <= RST_LOAD;
                            eng_rst   <= 1'b1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort || (out_xfer_s && out_last)) begin
                        state_r   <= ST_RECOVER;
                        rst_cnt_r <= RST_LOAD;
                        eng_rst   <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (out_xfer_s) begin
                        out_idx_r <= nxt_idx_s;
                        out_data  <= res_ram[nxt_idx_s[OUT_AW-1:0]];
                        out_last  <= (nxt_idx_s == OUT_LAST);
                    end
                end
                ST_RECOVER: begin
                    pix_cnt_r <= '0;
                    out_idx_r <= '0;
                    if (rst_cnt_r <= RST_W'(1)) begin
                        state_r <= ST_IDLE;
                        eng_rst <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        rst_cnt_r <= rst_cnt_r - RST_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_RECOVER;
                    rst_cnt_r <= RST_LOAD;
                    eng_rst   <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_io.sv
// Directed bench for cnn_frame_io: a small engine model fills res_ram from the image RAM
// with a 3x3 row-difference kernel plus ReLU; expected words are closed-form per test image.
module tb_cnn_frame_io;
    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        in_data;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        img_ram [64];
    logic               eng_start;
    logic               eng_rst;
    logic               eng_done = 1'b0;
    logic signed [31:0] res_ram [36];
    logic [31:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               abort;
    logic               busy;
    logic               err;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt    = 0;
    int start_viol   = 0;
    int eng_cnt      = 0;
    bit eng_run      = 1'b0;
    bit rst_seen     = 1'b0;
    bit done_en      = 1'b1;

    cnn_frame_io #(.IMG_W(8), .IMG_H(8), .WAIT_TIMEOUT(16), .ENG_RST_CYC(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .img_ram(img_ram), .eng_start(eng_start), .eng_rst(eng_rst), .eng_done(eng_done),
        .res_ram(res_ram), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .abort(abort), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pix_val(input int mode, input int i);
        int row;
        int col;
        row = i / 8;
        col = i % 8;
        case (mode)
            0:       return 32'(row * 8 + col);
            1:       return 32'(4 * row * row + col);
            2:       return 32'(1000 + 24 * row + 5 * col);
            default: return 32'(5000 + i);
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input int mode, input int k);
        int r;
        r = k / 6;
        case (mode)
            0:       return 32'd48;
            1:       return 32'(48 * (r + 1));
            2:       return 32'd144;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic signed [31:0] conv_px(input int r, input int c);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            s += int'(img_ram[(r + 2) * 8 + c + k]) - int'(img_ram[r * 8 + c + k]);
        end
        return (s > 0) ? 32'(s) : 32'sd0;
    endfunction

    // Engine model: sticky done a few cycles after start, cleared by eng_rst.
    always @(posedge clk) begin
        if (eng_rst) begin
            eng_done <= 1'b0;
            eng_run  <= 1'b0;
            eng_cnt  <= 0;
            rst_seen <= 1'b1;
        end else if (eng_start) begin
            eng_run   <= 1'b1;
            eng_cnt   <= 0;
            start_cnt <= start_cnt + 1;
            if (!rst_seen) start_viol <= start_viol + 1;
            rst_seen  <= 1'b0;
        end else if (eng_run && done_en) begin
            if (eng_cnt == 3) begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++)
                        res_ram[r * 6 + c] <= conv_px(r, c);
                eng_done <= 1'b1;
                eng_run  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    task automatic release_checks(input string tag);
        tick();
        check({tag, "_rst_hold"}, 32'(eng_rst), 32'd1);
        check({tag, "_busy_hold"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_rst_drop"}, 32'(eng_rst), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input int mode, input bit toggle, input int abort_at);
        int i;
        int cyc;
        bit ph;
        bit done;
        i = 0; cyc = 0; ph = 1'b1; done = 1'b0;
        while (!done && cyc < 2000) begin
            in_valid = toggle ? ph : 1'b1;
            ph       = ~ph;
            in_data  = pix_val(mode, i);
            abort    = 1'b0;
            if (in_valid && in_ready) begin
                if (i == abort_at) begin
                    abort = 1'b1;
                    done  = 1'b1;
                end else begin
                    i++;
                    if (i == 64) done = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        if (!done) check("fill_timeout", 32'(i), 32'd64);
        else if (abort_at < 0) check("kick_latency", 32'(eng_start), 32'd1);
    endtask

    task automatic recv_frame(input int mode, input bit stall);
        int k;
        int cyc;
        int st;
        k = 0; cyc = 0; st = 0;
        out_ready = 1'b1;
        while (!eng_done && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!eng_done) check("done_timeout", 32'(eng_done), 32'd1);
        tick();
        check("done_to_valid", 32'(out_valid), 32'd1);
        while (k < 36 && cyc < 2000) begin
            out_ready = 1'b1;
            if (out_valid) begin
                if (stall && (k == 0 || k == 17 || k == 35) && st < 3) begin
                    out_ready = 1'b0;
                    st++;
                    check("stall_hold", out_data, exp_word(mode, k));
                end else begin
                    check("data", out_data, exp_word(mode, k));
                    check("last", 32'(out_last), 32'(k == 35));
                    k++;
                    st = 0;
                end
            end
            tick();
            cyc++;
        end
        if (k < 36) check("drain_timeout", 32'(k), 32'd36);
        check("valid_drop", 32'(out_valid), 32'd0);
        check("recover_rst", 32'(eng_rst), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("rst_eng_rst", 32'(eng_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_start", 32'(eng_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_img0", img_ram[0], 32'd0);
        check("rst_img63", img_ram[63], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        release_checks("init");

        // Ramp frame, full-rate streams.
        send_frame(0, 1'b0, -1);
        recv_frame(0, 1'b0);
        check("starts_f1", 32'(start_cnt), 32'd1);

        // Toggled input valid and output stalls, then a back-to-back frame.
        send_frame(1, 1'b1, -1);
        recv_frame(1, 1'b1);
        send_frame(2, 1'b0, -1);
        recv_frame(2, 1'b0);
        check("starts_f3", 32'(start_cnt), 32'd3);
        check("start_after_rst", 32'(start_viol), 32'd0);

        // Abort on the pixel-40 transfer.
        send_frame(3, 1'b0, 40);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_eng_rst", 32'(eng_rst), 32'd1);
        repeat (8) tick();
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_no_start", 32'(start_cnt), 32'd3);
        check("abort_img39", img_ram[39], 32'd5039);
        check("abort_img40", img_ram[40], 32'd1120);
        check("abort_img0", img_ram[0], 32'd5000);

        // Engine never finishes: timeout after 16 WAIT cycles.
        done_en = 1'b0;
        send_frame(0, 1'b0, -1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 16) begin
                check("to_err_pre", 32'(err), 32'd0);
                check("to_busy_wait", 32'(busy), 32'd1);
            end
            if (k == 17) begin
                check("to_err_set", 32'(err), 32'd1);
                check("to_eng_rst", 32'(eng_rst), 32'd1);
            end
            if (k == 18) check("to_eng_rst_hold", 32'(eng_rst), 32'd1);
            if (k == 19) begin
                check("to_idle", 32'(busy), 32'd0);
                check("to_eng_rst_drop", 32'(eng_rst), 32'd0);
            end
        end
        repeat (5) tick();
        check("to_err_sticky", 32'(err), 32'd1);
        done_en = 1'b1;

        // Reset asserted in the middle of DRAIN.
        send_frame(0, 1'b0, -1);
        for (int c = 0; c < 200 && !eng_done; c++) tick();
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        check("mid_drain_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_eng_rst", 32'(eng_rst), 32'd1);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_last", 32'(out_last), 32'd0);
        @(negedge clk) rst = 1'b1;
        release_checks("mid");

        // Recovery frame after reset.
        send_frame(1, 1'b0, -1);
        recv_frame(1, 1'b0);
        check("start_after_rst_end", 32'(start_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
